// File: rtl/mips_pipeline_top.sv
// Five-stage in-order MIPS-I integer core: fetch, issue, execute, memory, write-back.
// Branches resolve in issue with one delay slot; the pipeline never stalls or flushes.

// Write-first 32x32 register file; register 0 always reads as zero.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic [31:0] rd_data_a_c,
    output logic [31:0] rd_data_b_c,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);
    logic [31:0] reg_file [0:31];

    // Register storage, cleared on reset; writes to register 0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                reg_file[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            reg_file[wr_addr] <= wr_data;
        end
    end

    // Read ports return the value being written this cycle when addresses collide.
    always_comb begin
        rd_data_a_c = reg_file[rd_addr_a];
        rd_data_b_c = reg_file[rd_addr_b];
        if (wr_en && (wr_addr != 5'd0) && (wr_addr == rd_addr_a)) begin
            rd_data_a_c = wr_data;
        end
        if (wr_en && (wr_addr != 5'd0) && (wr_addr == rd_addr_b)) begin
            rd_data_b_c = wr_data;
        end
    end
endmodule

module mips_pipeline_top #(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input logic clk,
    input logic reset
);
    localparam int unsigned IA_W = $clog2(IMEM_WORDS);
    localparam int unsigned DA_W = $clog2(DMEM_WORDS);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    // Fetch
    logic [31:0] curr_pc_pc_reg_fetch;
    logic [31:0] instr_pc_reg_fetch;
    logic [31:0] next_pc_c;

    // Issue
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        is_r_type_iss_ex, is_i_type_iss_ex, is_j_type_iss_ex;
    logic [4:0]  rs_iss_ex, rt_iss_ex, rd_iss_ex, shamt_c;
    logic [5:0]  opcode_c, funct_c;
    logic [15:0] imm_c;
    logic [31:0] imm_sext_c, imm_ext_c, seq_pc_c;
    logic [31:0] rf_a_c, rf_b_c, br_a_c, br_b_c;
    alu_op_e     dec_alu_op;
    logic        dec_use_imm, dec_use_shamt, dec_wr, dec_mem_rd, dec_mem_wr, dec_link;
    logic        dec_beq, dec_bne, dec_jump, dec_jump_reg;
    logic [4:0]  dec_dest;

    // Execute
    logic        id_ex_valid, id_ex_reg_wr, id_ex_mem_rd, id_ex_mem_wr, id_ex_link;
    logic        id_ex_use_imm, id_ex_use_shamt;
    logic [31:0] id_ex_pc, id_ex_a, id_ex_b, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest, id_ex_shamt;
    alu_op_e     id_ex_alu_op;
    logic [31:0] ex_a_c, ex_b_c, ex_opb_c, alu_out_c, ex_result_c;
    logic [4:0]  ex_sh_c;

    // Memory
    logic        ex_mem_valid, ex_mem_reg_wr, ex_mem_mem_rd, ex_mem_mem_wr;
    logic [31:0] ex_mem_result, ex_mem_store;
    logic [4:0]  ex_mem_dest;
    logic [31:0] dmem_rdata_c, mem_result_c;

    // Write-back
    logic        instr_retired, reg_wr_wb_ret;
    logic [4:0]  wr_dest_wb_ret;
    logic [31:0] wr_data_rf_wb_ret;

    assign instr_pc_reg_fetch = imem[curr_pc_pc_reg_fetch[IA_W+1:2]];

    // Issue-stage field extraction and instruction class.
    assign opcode_c   = if_id_instr[31:26];
    assign funct_c    = if_id_instr[5:0];
    assign rs_iss_ex  = if_id_instr[25:21];
    assign rt_iss_ex  = if_id_instr[20:16];
    assign rd_iss_ex  = if_id_instr[15:11];
    assign shamt_c    = if_id_instr[10:6];
    assign imm_c      = if_id_instr[15:0];
    assign imm_sext_c = {{16{imm_c[15]}}, imm_c};
    assign seq_pc_c   = if_id_pc + 32'd4;
    assign is_r_type_iss_ex = if_id_valid && (opcode_c == 6'h00);
    assign is_j_type_iss_ex = if_id_valid && ((opcode_c == 6'h02) || (opcode_c == 6'h03));
    assign is_i_type_iss_ex = if_id_valid && !is_r_type_iss_ex && !is_j_type_iss_ex;

    mips_regfile R1 (
        .clk         (clk),
        .rst_n       (reset),
        .rd_addr_a   (rs_iss_ex),
        .rd_addr_b   (rt_iss_ex),
        .rd_data_a_c (rf_a_c),
        .rd_data_b_c (rf_b_c),
        .wr_en       (reg_wr_wb_ret && instr_retired),
        .wr_addr     (wr_dest_wb_ret),
        .wr_data     (wr_data_rf_wb_ret)
    );

    // Instruction decode into control fields; unknown encodings behave as nop.
    always_comb begin
        dec_alu_op    = ALU_ADD;
        dec_use_imm   = 1'b0;
        dec_use_shamt = 1'b0;
        dec_wr        = 1'b0;
        dec_dest      = rd_iss_ex;
        dec_mem_rd    = 1'b0;
        dec_mem_wr    = 1'b0;
        dec_link      = 1'b0;
        dec_beq       = 1'b0;
        dec_bne       = 1'b0;
        dec_jump      = 1'b0;
        dec_jump_reg  = 1'b0;
        imm_ext_c     = imm_sext_c;
        if (is_r_type_iss_ex) begin
            dec_wr = 1'b1;
            case (funct_c)
                6'h20, 6'h21: dec_alu_op = ALU_ADD;
                6'h22, 6'h23: dec_alu_op = ALU_SUB;
                6'h24:        dec_alu_op = ALU_AND;
                6'h25:        dec_alu_op = ALU_OR;
                6'h26:        dec_alu_op = ALU_XOR;
                6'h27:        dec_alu_op = ALU_NOR;
                6'h2A:        dec_alu_op = ALU_SLT;
                6'h2B:        dec_alu_op = ALU_SLTU;
                6'h00: begin dec_alu_op = ALU_SLL; dec_use_shamt = 1'b1; end
                6'h02: begin dec_alu_op = ALU_SRL; dec_use_shamt = 1'b1; end
                6'h03: begin dec_alu_op = ALU_SRA; dec_use_shamt = 1'b1; end
                6'h04:        dec_alu_op = ALU_SLL;
                6'h06:        dec_alu_op = ALU_SRL;
                6'h07:        dec_alu_op = ALU_SRA;
                6'h08: begin dec_jump_reg = 1'b1; dec_wr = 1'b0; end
                default:      dec_wr = 1'b0;
            endcase
        end else if (is_j_type_iss_ex) begin
            dec_jump = 1'b1;
            if (opcode_c == 6'h03) begin
                dec_link = 1'b1;
                dec_wr   = 1'b1;
                dec_dest = 5'd31;
            end
        end else if (is_i_type_iss_ex) begin
            dec_dest    = rt_iss_ex;
            dec_use_imm = 1'b1;
            case (opcode_c)
                6'h08, 6'h09: dec_wr = 1'b1;
                6'h0C: begin dec_wr = 1'b1; dec_alu_op = ALU_AND; imm_ext_c = {16'h0, imm_c}; end
                6'h0D: begin dec_wr = 1'b1; dec_alu_op = ALU_OR;  imm_ext_c = {16'h0, imm_c}; end
                6'h0E: begin dec_wr = 1'b1; dec_alu_op = ALU_XOR; imm_ext_c = {16'h0, imm_c}; end
                6'h0A: begin dec_wr = 1'b1; dec_alu_op = ALU_SLT;  end
                6'h0B: begin dec_wr = 1'b1; dec_alu_op = ALU_SLTU; end
                6'h0F: begin dec_wr = 1'b1; dec_alu_op = ALU_LUI;  end
                6'h23: begin dec_wr = 1'b1; dec_mem_rd = 1'b1; end
                6'h2B: dec_mem_wr = 1'b1;
                6'h04: dec_beq = 1'b1;
                6'h05: dec_bne = 1'b1;
                default: ;
            endcase
        end
    end

    // Branch operands bypassed from execute (highest priority) and memory stages.
    always_comb begin
        br_a_c = rf_a_c;
        br_b_c = rf_b_c;
        if (ex_mem_valid && ex_mem_reg_wr && (ex_mem_dest == rs_iss_ex)) br_a_c = mem_result_c;
        if (ex_mem_valid && ex_mem_reg_wr && (ex_mem_dest == rt_iss_ex)) br_b_c = mem_result_c;
        if (id_ex_valid && id_ex_reg_wr && (id_ex_dest == rs_iss_ex)) br_a_c = ex_result_c;
        if (id_ex_valid && id_ex_reg_wr && (id_ex_dest == rt_iss_ex)) br_b_c = ex_result_c;
    end

    // Next PC: redirect from the issue stage, the delay slot is already in fetch.
    always_comb begin
        next_pc_c = curr_pc_pc_reg_fetch + 32'd4;
        if (dec_jump_reg) begin
            next_pc_c = br_a_c;
        end else if (dec_jump) begin
            next_pc_c = {seq_pc_c[31:28], if_id_instr[25:0], 2'b00};
        end else if ((dec_beq && (br_a_c == br_b_c)) || (dec_bne && (br_a_c != br_b_c))) begin
            next_pc_c = seq_pc_c + {imm_sext_c[29:0], 2'b00};
        end
    end

    // Execute operand bypass, EX/MEM taking priority over MEM/WB.
    always_comb begin
        ex_a_c = id_ex_a;
        ex_b_c = id_ex_b;
        if (reg_wr_wb_ret && (wr_dest_wb_ret == id_ex_rs)) ex_a_c = wr_data_rf_wb_ret;
        if (reg_wr_wb_ret && (wr_dest_wb_ret == id_ex_rt)) ex_b_c = wr_data_rf_wb_ret;
        if (ex_mem_valid && ex_mem_reg_wr && (ex_mem_dest == id_ex_rs)) ex_a_c = ex_mem_result;
        if (ex_mem_valid && ex_mem_reg_wr && (ex_mem_dest == id_ex_rt)) ex_b_c = ex_mem_result;
    end

    assign ex_opb_c    = id_ex_use_imm ? id_ex_imm : ex_b_c;
    assign ex_sh_c     = id_ex_use_shamt ? id_ex_shamt : ex_a_c[4:0];
    assign ex_result_c = id_ex_link ? (id_ex_pc + 32'd8) : alu_out_c;

    // ALU.
    always_comb begin
        alu_out_c = '0;
        case (id_ex_alu_op)
            ALU_ADD:  alu_out_c = ex_a_c + ex_opb_c;
            ALU_SUB:  alu_out_c = ex_a_c - ex_opb_c;
            ALU_AND:  alu_out_c = ex_a_c & ex_opb_c;
            ALU_OR:   alu_out_c = ex_a_c | ex_opb_c;
            ALU_XOR:  alu_out_c = ex_a_c ^ ex_opb_c;
            ALU_NOR:  alu_out_c = ~(ex_a_c | ex_opb_c);
            ALU_SLT:  alu_out_c = 32'($signed(ex_a_c) < $signed(ex_opb_c));
            ALU_SLTU: alu_out_c = 32'(ex_a_c < ex_opb_c);
            ALU_SLL:  alu_out_c = ex_opb_c << ex_sh_c;
            ALU_SRL:  alu_out_c = ex_opb_c >> ex_sh_c;
            ALU_SRA:  alu_out_c = 32'($signed(ex_opb_c) >>> ex_sh_c);
            ALU_LUI:  alu_out_c = {ex_opb_c[15:0], 16'h0000};
            default:  alu_out_c = '0;
        endcase
    end

    assign dmem_rdata_c = dmem[ex_mem_result[DA_W+1:2]];
    assign mem_result_c = ex_mem_mem_rd ? dmem_rdata_c : ex_mem_result;

    // Data memory write port, word aligned.
    always_ff @(posedge clk) begin
        if (ex_mem_valid && ex_mem_mem_wr) begin
            dmem[ex_mem_result[DA_W+1:2]] <= ex_mem_store;
        end
    end

    // PC and all pipeline registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curr_pc_pc_reg_fetch <= RESET_PC;
            if_id_valid <= 1'b0; if_id_pc <= '0; if_id_instr <= '0;
            id_ex_valid <= 1'b0; id_ex_pc <= '0; id_ex_a <= '0; id_ex_b <= '0; id_ex_imm <= '0;
            id_ex_rs <= '0; id_ex_rt <= '0; id_ex_dest <= '0; id_ex_shamt <= '0;
            id_ex_alu_op <= ALU_ADD; id_ex_use_imm <= 1'b0; id_ex_use_shamt <= 1'b0;
            id_ex_reg_wr <= 1'b0; id_ex_mem_rd <= 1'b0; id_ex_mem_wr <= 1'b0; id_ex_link <= 1'b0;
            ex_mem_valid <= 1'b0; ex_mem_reg_wr <= 1'b0; ex_mem_mem_rd <= 1'b0; ex_mem_mem_wr <= 1'b0;
            ex_mem_result <= '0; ex_mem_store <= '0; ex_mem_dest <= '0;
            instr_retired <= 1'b0; reg_wr_wb_ret <= 1'b0; wr_dest_wb_ret <= '0; wr_data_rf_wb_ret <= '0;
        end else begin
            curr_pc_pc_reg_fetch <= next_pc_c;
            if_id_valid <= 1'b1;
            if_id_pc    <= curr_pc_pc_reg_fetch;
            if_id_instr <= instr_pc_reg_fetch;

            id_ex_valid     <= if_id_valid;
            id_ex_pc        <= if_id_pc;
            id_ex_a         <= rf_a_c;
            id_ex_b         <= rf_b_c;
            id_ex_imm       <= imm_ext_c;
            id_ex_rs        <= rs_iss_ex;
            id_ex_rt        <= rt_iss_ex;
            id_ex_dest      <= dec_dest;
            id_ex_shamt     <= shamt_c;
            id_ex_alu_op    <= dec_alu_op;
            id_ex_use_imm   <= dec_use_imm;
            id_ex_use_shamt <= dec_use_shamt;
            id_ex_reg_wr    <= dec_wr && (dec_dest != 5'd0);
            id_ex_mem_rd    <= dec_mem_rd;
            id_ex_mem_wr    <= dec_mem_wr;
            id_ex_link      <= dec_link;

            ex_mem_valid  <= id_ex_valid;
            ex_mem_reg_wr <= id_ex_valid && id_ex_reg_wr;
            ex_mem_mem_rd <= id_ex_mem_rd;
            ex_mem_mem_wr <= id_ex_mem_wr;
            ex_mem_result <= ex_result_c;
            ex_mem_store  <= ex_b_c;
            ex_mem_dest   <= id_ex_dest;

            instr_retired     <= ex_mem_valid;
            reg_wr_wb_ret     <= ex_mem_valid && ex_mem_reg_wr;
            wr_dest_wb_ret    <= ex_mem_dest;
            wr_data_rf_wb_ret <= mem_result_c;
        end
    end
endmodule

// File: tb/tb_mips_pipeline_top.sv
// Directed program bench: checks every retirement, key fetch/decode points,
// final architectural state, and restart after an asynchronous mid-run reset.
module tb_mips_pipeline_top;
    localparam int unsigned LAST_K = 23;  // index of the syscall in retirement order
    localparam int unsigned N_PROG = 26;

    logic clk_tb = 1'b0;
    logic rst_n;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] prog     [0:N_PROG-1];
    logic        exp_wr   [0:LAST_K];
    logic [31:0] exp_data [0:LAST_K];
    logic [31:0] exp_reg  [0:14];

    mips_pipeline_top dut (
        .clk   (clk_tb),
        .reset (rst_n)
    );

    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Release reset and walk the program cycle by cycle through syscall retirement.
    task automatic run_program(input string tag);
        @(negedge clk_tb);
        rst_n = 1'b1;
        #1;
        chk({tag, " pc s0"}, dut.curr_pc_pc_reg_fetch, 32'h0000_0000);
        chk({tag, " instr s0"}, dut.instr_pc_reg_fetch, 32'h2401_0005);
        chk({tag, " retired s0"}, 32'(dut.instr_retired), 32'd0);
        for (int s = 1; s <= int'(LAST_K) + 4; s++) begin
            @(negedge clk_tb);
            if (s >= 4) begin
                chk($sformatf("%s retired s%0d", tag, s), 32'(dut.instr_retired), 32'd1);
                chk($sformatf("%s reg_wr s%0d", tag, s), 32'(dut.reg_wr_wb_ret), 32'(exp_wr[s-4]));
                if (exp_wr[s-4])
                    chk($sformatf("%s wb_data s%0d", tag, s), dut.wr_data_rf_wb_ret, exp_data[s-4]);
            end else begin
                chk($sformatf("%s retired s%0d", tag, s), 32'(dut.instr_retired), 32'd0);
            end
            if (s == 3) begin
                chk({tag, " addu is_r"}, 32'(dut.is_r_type_iss_ex), 32'd1);
                chk({tag, " addu is_i"}, 32'(dut.is_i_type_iss_ex), 32'd0);
                chk({tag, " addu is_j"}, 32'(dut.is_j_type_iss_ex), 32'd0);
                chk({tag, " addu rs"}, 32'(dut.rs_iss_ex), 32'd1);
                chk({tag, " addu rt"}, 32'(dut.rt_iss_ex), 32'd2);
                chk({tag, " addu rd"}, 32'(dut.rd_iss_ex), 32'd3);
            end
            if (s == 15) begin
                chk({tag, " beq is_i"}, 32'(dut.is_i_type_iss_ex), 32'd1);
                chk({tag, " beq is_r"}, 32'(dut.is_r_type_iss_ex), 32'd0);
            end
            if (s == 16) chk({tag, " beq target pc"}, dut.curr_pc_pc_reg_fetch, 32'd68);
            if (s == 22) chk({tag, " bne target pc"}, dut.curr_pc_pc_reg_fetch, 32'd96);
            if (s == 24) chk({tag, " syscall is_r"}, 32'(dut.is_r_type_iss_ex), 32'd1);
        end
        chk({tag, " syscall v0"}, dut.R1.reg_file[2], 32'd10);
        for (int r = 0; r <= 14; r++) begin
            chk($sformatf("%s reg%0d", tag, r), dut.R1.reg_file[r], exp_reg[r]);
        end
        chk({tag, " dmem2"}, dut.dmem[2], 32'h1234_FFFF);
    endtask

    initial begin
        prog = '{32'h24010005, 32'h24020007, 32'h00221821, 32'h3C041234,
                 32'h3484FFFF, 32'h30858000, 32'h2806FFFF, 32'h388BFFFF,
                 32'h2C06FFFF, 32'hAC040008, 32'h00000000, 32'h8C070008,
                 32'h00000000, 32'h00E04021, 32'h10000002, 32'h24090001,
                 32'h24090002, 32'h240A0003, 32'h24000009, 32'h00416023,
                 32'h00016900, 32'h15A00002, 32'h240E0005, 32'h240E0006,
                 32'h2402000A, 32'h0000000C};
        exp_wr   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                     1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_data = '{32'd5, 32'd7, 32'd12, 32'h12340000,
                     32'h1234FFFF, 32'h00008000, 32'd0, 32'h12340000,
                     32'd1, 32'd0, 32'd0, 32'h1234FFFF,
                     32'd0, 32'h1234FFFF, 32'd0, 32'd1,
                     32'd3, 32'd0, 32'd2, 32'd80,
                     32'd0, 32'd5, 32'd10, 32'd0};
        exp_reg  = '{32'd0, 32'd5, 32'd10, 32'd12, 32'h1234FFFF,
                     32'h00008000, 32'd1, 32'h1234FFFF, 32'h1234FFFF, 32'd1,
                     32'd3, 32'h12340000, 32'd2, 32'd80, 32'd5};

        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0;
        for (int i = 0; i < int'(N_PROG); i++) dut.imem[i] = prog[i];

        repeat (2) @(negedge clk_tb);
        chk("reset retired", 32'(dut.instr_retired), 32'd0);
        chk("reset reg_wr", 32'(dut.reg_wr_wb_ret), 32'd0);
        chk("reset pc", dut.curr_pc_pc_reg_fetch, 32'h0000_0000);
        chk("reset reg1", dut.R1.reg_file[1], 32'd0);

        run_program("run1");

        // Asynchronous reset in mid-cycle while instructions are retiring.
        #2 rst_n = 1'b0;
        #1;
        chk("async retired", 32'(dut.instr_retired), 32'd0);
        chk("async reg_wr", 32'(dut.reg_wr_wb_ret), 32'd0);
        chk("async pc", dut.curr_pc_pc_reg_fetch, 32'h0000_0000);
        chk("async reg1 cleared", dut.R1.reg_file[1], 32'd0);
        repeat (5) begin
            @(negedge clk_tb);
            chk("held retired", 32'(dut.instr_retired), 32'd0);
            chk("held pc", dut.curr_pc_pc_reg_fetch, 32'h0000_0000);
        end

        run_program("run2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
